fxo_demux: RTL
==============

# fxo_demux

Registered 1-to-4 stream demultiplexer, the write-side counterpart of the 4:1 mux in the combinational library. It accepts one valid/ready input stream and steers each word, by a 2-bit select sampled with the word, into one of four independently back-pressured output channels. Each channel has a one-entry output register and an 8-bit delivered-word counter.

## Interface
- `WIDTH`, default 8: data width per word; legal range ≥1.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset; release is synchronous to `clk`.
- `in_valid`  input  1  input word present.
- `in_ready`  output  1  block accepts the input word this cycle.
- `in_data`  input  WIDTH  input word.
- `in_sel`  input  2  destination channel for `in_data`; qualified by `in_valid`.
- `out_valid`  output  4  bit k: channel k holds a word.
- `out_ready`  input  4  bit k: consumer of channel k takes the word.
- `out_data`  output  4*WIDTH  channel k data on bits [k*WIDTH +: WIDTH].
- `cnt_clr`  input  1  synchronous clear of all delivery counters.
- `out_cnt`  output  32  channel k count on bits [k*8 +: 8]; counts words delivered, wraps 255→0.

## Operation
- Input handshake fires when `in_valid && in_ready`. Output k handshake fires when `out_valid[k] && out_ready[k]`.
- Each channel k is a two-state register: EMPTY (`out_valid[k]=0`) and FULL (`out_valid[k]=1`).
  - EMPTY → FULL: an input handshake fires with `in_sel==k`.
  - FULL → EMPTY: output k fires and no input handshake fires with `in_sel==k`.
  - FULL → FULL with new data: output k fires and an input handshake fires with `in_sel==k` in the same cycle.
  - FULL, no output k handshake: hold data and valid; input to k is stalled.
- `in_ready = !out_valid[in_sel] || out_ready[in_sel]`. This is combinational from `in_sel`, `out_valid`, and `out_ready`, and does not depend on `in_valid`.
- Channels are independent. A stalled channel never blocks words addressed to another channel. No reordering within a channel.
- `out_data[k]` changes only on an input handshake to k. When the channel is EMPTY it holds its last value, and the value is don't-care.
- Counter k increments on each output k handshake and wraps modulo 256.
- `cnt_clr` sets all counters to 0 and takes priority over a same-cycle increment. It does not affect the data path.
- `in_sel` is ignored when `in_valid` is 0, except that it still drives the `in_ready` computation.

## Timing
- Latency: an input accepted at edge N appears on `out_valid[k]`/`out_data[k]` after edge N, and is consumable in cycle N+1. No combinational path from `in_data` to `out_data`.
- Throughput: 1 word/cycle sustained into any channel whose consumer holds `out_ready[k]=1`.
- Reset values: `out_valid=4'b0000`, `out_data` all zeros, `out_cnt` all zeros.
- `in_ready` is a combinational output. With all channels EMPTY after reset, `in_ready=1`.
- Reset asserted mid-transfer: all channels go EMPTY immediately, buffered words are lost, and counters are zeroed. There is no handshake during reset.
- Simultaneous input to channel k and output from channel k while FULL: both fire, the new word replaces the old one, and `out_valid[k]` stays 1.

## Test plan
- Reset and basic routing:
  - After `rst_n` deasserts, `in_ready=1`, `out_valid=0`, and `out_cnt=0`.
  - Send 0xA0..0xA3 with `in_sel` 0..3 on consecutive cycles, all `out_ready=1`.
  - Required: each `out_valid[k]` pulses one cycle after its send, with `out_data[k]=0xA0+k`, and each `out_cnt` byte ends at 1.
- Back-pressure isolation:
  - Hold `out_ready[2]=0` and send 0x11 then 0x22 to channel 2.
  - Required: 0x11 is held, and `in_ready=0` while `in_sel=2`.
  - Send 0x33 to channel 1 in the meantime: it is accepted and delivered. Then raise `out_ready[2]`: 0x11 then 0x22 come out in order.
- Full streaming:
  - 300 back-to-back words to channel 3 with `out_ready[3]=1`.
  - Required: one word per cycle, `in_ready` held at 1, and `out_cnt[31:24]=300 mod 256=44`.
- Simultaneous fill and drain:
  - Channel 0 is FULL with 0x55 and `out_ready[0]=1`; input 0x66 to channel 0 in the same cycle.
  - Required: 0x55 is consumed, next cycle `out_data[0]=0x66`, and `out_valid[0]` stays 1 throughout.
- `cnt_clr` priority:
  - Assert `cnt_clr` in the same cycle as an output 1 handshake.
  - Required: `out_cnt[15:8]=0` next cycle, and the data path is unaffected.
- Mid-operation reset:
  - Pull `rst_n` low while channels 0 and 2 are FULL.
  - Required: `out_valid=0` and `out_cnt=0` without waiting for a clock edge. After release, the first word sent is delivered normally.

Source files
------------

// File: rtl/fxo_demux.sv
// fxo_demux: registered 1-to-4 valid/ready stream demultiplexer with per-channel delivery counters
module fxo_demux #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    input  logic               cnt_clr,
    output logic [31:0]        out_cnt
);
    typedef enum logic {EMPTY, FULL} st_t;
    st_t              st    [4];
    st_t              st_nx [4];
    logic [3:0]       in_hit;
    logic [3:0]       out_hit;
    logic [WIDTH-1:0] data  [4];
    logic [7:0]       cnt   [4];

    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];

    for (genvar k = 0; k < 4; k++) begin : g_ch
        assign out_valid[k]                 = st[k] == FULL;
        assign out_data[k*WIDTH +: WIDTH]   = data[k];
        assign out_cnt[k*8 +: 8]            = cnt[k];
    end

    // per-channel handshakes and EMPTY/FULL next state; a FULL channel refills in place when drained and loaded together
    always_comb begin
        in_hit  = '0;
        out_hit = '0;
        for (int i = 0; i < 4; i++) begin
            st_nx[i]   = st[i];
            in_hit[i]  = in_valid && in_ready && in_sel == 2'(i);
            out_hit[i] = out_valid[i] && out_ready[i];
            st_nx[i]   = (st[i] == EMPTY) ? (in_hit[i] ? FULL : EMPTY)
                                          : ((out_hit[i] && !in_hit[i]) ? EMPTY : FULL);
        end
    end

    // channel state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) st[i] <= EMPTY;
        end else begin
            for (int i = 0; i < 4; i++) st[i] <= st_nx[i];
        end
    end

    // output data registers load only on an accepted word; counters clear with priority over delivery
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                data[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (in_hit[i]) data[i] <= in_data;
                cnt[i] <= cnt_clr ? 8'd0 : cnt[i] + 8'(out_hit[i]);
            end
        end
    end
endmodule
